// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: DEPTH-entry circular buffer of {pc, inst} pairs between fetch and decode.
// Handshake: fetch transfers an entry on a rising edge where in_valid && in_ready (and no flushD);
// decode consumes the head on an edge where out_valid && !bubbleD && !flushD.
module if_id_fetch_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_inst,
  input  logic              bubbleD,
  input  logic              flushD,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;

  // in_ready comes only from the registered count, so stalls and flushes never reach it.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flushD;
  assign pop       = out_valid && !bubbleD && !flushD;

  assign out_pc   = out_valid ? pc_mem[rd_ptr]   : '0;
  assign out_inst = out_valid ? inst_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flushD) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // The tail never aliases the head while entries are queued, so the head is stable during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_if_id_fetch_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [DATA_W-1:0] in_inst;
  logic              bubbleD;
  logic              flushD;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  if_id_fetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .bubbleD(bubbleD), .flushD(flushD),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n = exp_q.size();
    check("count", 64'(count), 64'(n));
    check("in_ready", 64'(in_ready), 64'(n != DEPTH));
    check("out_valid", 64'(out_valid), 64'(n != 0));
    if (n != 0) begin
      check("out_pc", 64'(out_pc), 64'(exp_q[0][ADDR_W+DATA_W-1:DATA_W]));
      check("out_inst", 64'(out_inst), 64'(exp_q[0][DATA_W-1:0]));
    end else begin
      check("out_pc_zero", 64'(out_pc), 64'd0);
      check("out_inst_zero", 64'(out_inst), 64'd0);
    end
  endtask

  // driver: set inputs (called at the negedge)
  task automatic drive(input logic v, input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] inst,
                       input logic bub, input logic fl);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst;
    bubbleD  = bub;
    flushD   = fl;
  endtask

  // advance one clock, update the model from the pre-edge inputs, check at the next negedge
  task automatic step();
    int  n = exp_q.size();
    bit  push;
    bit  pop;
    push = in_valid && (n != DEPTH) && !flushD;
    pop  = (n != 0) && !bubbleD && !flushD;
    @(posedge clk);
    if (flushD) exp_q.delete();
    else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back({in_pc, in_inst});
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic go(input logic v, input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] inst,
                    input logic bub, input logic fl);
    drive(v, pc, inst, bub, fl);
    step();
  endtask

  logic [DATA_W-1:0] fill_inst [4];

  initial begin
    fill_inst[0] = 32'h0000_0013;
    fill_inst[1] = 32'h0010_0093;
    fill_inst[2] = 32'h0020_0113;
    fill_inst[3] = 32'h0030_0193;
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // fill under stall, 5th push refused, then drain in order
    for (int i = 0; i < 4; i++) go(1'b1, ADDR_W'(4 * i), fill_inst[i], 1'b1, 1'b0);
    go(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) go(1'b0, '0, '0, 1'b0, 1'b0);

    // stall hold with head pc 0x8 while pushes continue
    for (int i = 0; i < 3; i++) go(1'b1, ADDR_W'(4 * i), 32'h100 + DATA_W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      go(1'b1, ADDR_W'(12 + 4 * i), 32'h200 + DATA_W'(i), 1'b1, 1'b0);
      check("stall_pc", 64'(out_pc), 64'h8);
      check("stall_inst", 64'(out_inst), 64'h102);
    end
    go(1'b0, '0, '0, 1'b0, 1'b0);
    go(1'b0, '0, '0, 1'b0, 1'b0);

    // flush with simultaneous push, then push 0x44
    check("pre_flush_count", 64'(count), 64'd2);
    go(1'b1, 32'h40, 32'h4000, 1'b0, 1'b1);
    go(1'b1, 32'h44, 32'h4400, 1'b1, 1'b0);
    check("post_flush_pc", 64'(out_pc), 64'h44);

    // wrap-around: push+pop at count=1
    for (int i = 0; i < 10; i++) go(1'b1, 32'h500 + ADDR_W'(4 * i), 32'h5000 + DATA_W'(i), 1'b0, 1'b0);
    go(1'b0, '0, '0, 1'b0, 1'b0);

    // asynchronous reset mid-stall at count=3
    for (int i = 0; i < 3; i++) go(1'b1, 32'h600 + ADDR_W'(4 * i), 32'h6000 + DATA_W'(i), 1'b1, 1'b0);
    check("pre_reset_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // bubble on empty: entry still enters and is held
    go(1'b1, 32'h100, 32'hABCD, 1'b1, 1'b0);
    go(1'b0, '0, '0, 1'b1, 1'b0);
    go(1'b0, '0, '0, 1'b1, 1'b0);
    check("bubble_empty_pc", 64'(out_pc), 64'h100);
    go(1'b0, '0, '0, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 300; i++)
      go(1'($urandom_range(0, 3) != 0), ADDR_W'($urandom), DATA_W'($urandom),
         1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
